// File: rtl/phase_accumulator_ctrl_if.sv
// rtl/phase_accumulator_ctrl_if.sv - control and adder-slice bus of the phase accumulator
// PHASE_ACC_HARD_SYNC_EN adds the hard-sync input to the bus.
interface phase_accumulator_ctrl_if #(
  parameter int W = 20
);
  logic         start;
  logic [W-1:0] step;
  logic         busy;
  logic         done;
  logic [W-1:0] phase;
  logic         wrap;
  logic [4:0]   add_a;
  logic [4:0]   add_b;
  logic         add_cin;
  logic [4:0]   add_sum;
  logic         add_cout;
`ifdef PHASE_ACC_HARD_SYNC_EN
  logic         sync;

  modport master (
    output start, step, add_sum, add_cout, sync,
    input  busy, done, phase, wrap, add_a, add_b, add_cin
  );

  modport slave (
    input  start, step, add_sum, add_cout, sync,
    output busy, done, phase, wrap, add_a, add_b, add_cin
  );
`else
  modport master (
    output start, step, add_sum, add_cout,
    input  busy, done, phase, wrap, add_a, add_b, add_cin
  );

  modport slave (
    input  start, step, add_sum, add_cout,
    output busy, done, phase, wrap, add_a, add_b, add_cin
  );
`endif
endinterface

// File: rtl/phase_accumulator_ctrl.sv
// rtl/phase_accumulator_ctrl.sv - wide phase accumulator time-multiplexed over a 5-bit adder
// PHASE_ACC_HARD_SYNC_EN enables oscillator hard sync (phase forced to 0 at commit).
module phase_accumulator_ctrl #(
  parameter int NUM_SLICES = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  phase_accumulator_ctrl_if.slave  bus
);
  localparam int W  = 5 * NUM_SLICES;
  localparam int SW = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam logic [SW-1:0] LAST_SLICE = SW'(NUM_SLICES - 1);

  typedef enum logic [1:0] {IDLE, ADD, COMMIT} state_t;

  state_t        r_state;
  logic [W-1:0]  r_phase;
  logic [W-1:0]  r_work;
  logic [W-1:0]  r_step;
  logic [SW-1:0] r_slice;
  logic          r_carry;
  logic          r_busy;
  logic          r_done;
  logic          r_wrap;
  logic          w_in_add;

  assign w_in_add    = (r_state == ADD);
  assign bus.add_a   = w_in_add ? r_work[5*r_slice +: 5] : 5'd0;
  assign bus.add_b   = w_in_add ? r_step[5*r_slice +: 5] : 5'd0;
  assign bus.add_cin = (w_in_add && (r_slice != '0)) ? r_carry : 1'b0;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.phase   = r_phase;

`ifdef PHASE_ACC_HARD_SYNC_EN
  logic r_sync_pend;
  logic w_sync_now;

  // A sync arriving on the commit edge itself still applies to that commit.
  assign w_sync_now = r_sync_pend | bus.sync;
  assign bus.wrap   = r_wrap | ((r_state == COMMIT) && w_sync_now);
`else
  assign bus.wrap   = r_wrap;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_phase <= '0;
      r_work  <= '0;
      r_step  <= '0;
      r_slice <= '0;
      r_carry <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_wrap  <= 1'b0;
`ifdef PHASE_ACC_HARD_SYNC_EN
      r_sync_pend <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      r_wrap <= 1'b0;
`ifdef PHASE_ACC_HARD_SYNC_EN
      if (bus.sync) r_sync_pend <= 1'b1;
`endif
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_step  <= bus.step;
            r_work  <= r_phase;
            r_slice <= '0;
            r_carry <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= ADD;
          end
        end
        ADD: begin
          r_work[5*r_slice +: 5] <= bus.add_sum;
          r_carry                <= bus.add_cout;
          r_slice                <= r_slice + 1'b1;
          // Top-slice carry out becomes the wrap pulse shown alongside done.
          if (r_slice == LAST_SLICE) begin
            r_slice <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_wrap  <= bus.add_cout;
            r_state <= COMMIT;
          end
        end
        COMMIT: begin
`ifdef PHASE_ACC_HARD_SYNC_EN
          if (w_sync_now) begin
            r_phase     <= '0;
            r_sync_pend <= 1'b0;
          end else begin
            r_phase <= r_work;
          end
`else
          r_phase <= r_work;
`endif
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_phase_accumulator_ctrl.sv
// tb/tb_phase_accumulator_ctrl.sv - directed self-checking bench for phase_accumulator_ctrl
module tb_phase_accumulator_ctrl;
  localparam int NS = 4;
  localparam int W  = 5 * NS;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  phase_accumulator_ctrl_if #(.W(W)) bus ();

  phase_accumulator_ctrl #(.NUM_SLICES(NS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural stand-in for the external 5-bit ripple adder.
  assign {bus.add_cout, bus.add_sum} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {5'd0, bus.add_cin};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sync(input logic v);
`ifdef PHASE_ACC_HARD_SYNC_EN
    bus.sync = v;
`else
    if (v) $display("note: sync requested without hard-sync build");
`endif
  endtask

  task automatic run_acc(input logic [W-1:0] s, input int sync_cyc, output int lat,
                         output int nbusy, output logic w_done, output logic [W-1:0] p_done,
                         output logic cin1, output logic [4:0] b0);
    lat = -1; nbusy = 0; w_done = 1'b0; p_done = '0; cin1 = 1'b0; b0 = '0;
    bus.start = 1'b1;
    bus.step  = s;
    tick();
    bus.start = 1'b0;
    bus.step  = ~s;
    for (int c = 1; c <= 20; c++) begin
      set_sync(c == sync_cyc);
      if (bus.busy) nbusy++;
      if (c == 1) b0 = bus.add_b;
      if (c == 2) cin1 = bus.add_cin;
      if (bus.done) begin
        lat = c; w_done = bus.wrap; p_done = bus.phase;
        break;
      end
      tick();
    end
    set_sync(1'b0);
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
    checks++; if (bus.wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap got %b want 0", bus.wrap); end
    checks++; if (bus.phase !== 20'h0) begin errors++; $display("FAIL reset_phase got %h want 0", bus.phase); end
    checks++; if ({bus.add_a, bus.add_b, bus.add_cin} !== 11'h0) begin
      errors++; $display("FAIL reset_adder_ops got %h want 0", {bus.add_a, bus.add_b, bus.add_cin});
    end
  endtask

  task automatic test_basic();
    int lat, nb; logic wd, c1; logic [W-1:0] pd; logic [4:0] b0;
    run_acc(20'h00001, 0, lat, nb, wd, pd, c1, b0);
    checks++; if (lat !== 5) begin errors++; $display("FAIL basic_latency got %0d want 5", lat); end
    checks++; if (nb !== 4) begin errors++; $display("FAIL basic_busy_cycles got %0d want 4", nb); end
    checks++; if (pd !== 20'h0) begin errors++; $display("FAIL basic_phase_held_on_done got %h want 0", pd); end
    checks++; if (wd !== 1'b0) begin errors++; $display("FAIL basic_wrap got %b want 0", wd); end
    checks++; if (bus.phase !== 20'h00001) begin errors++; $display("FAIL basic_phase got %h want 00001", bus.phase); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b want 0", bus.done); end
  endtask

  task automatic test_carry();
    int lat, nb; logic wd, c1; logic [W-1:0] pd; logic [4:0] b0;
    run_acc(20'h0001E, 0, lat, nb, wd, pd, c1, b0);
    checks++; if (bus.phase !== 20'h0001F) begin errors++; $display("FAIL carry_setup got %h want 0001F", bus.phase); end
    run_acc(20'h00001, 0, lat, nb, wd, pd, c1, b0);
    checks++; if (b0 !== 5'h01) begin errors++; $display("FAIL carry_add_b_s0 got %h want 01", b0); end
    checks++; if (c1 !== 1'b1) begin errors++; $display("FAIL carry_cin_s1 got %b want 1", c1); end
    checks++; if (bus.phase !== 20'h00020) begin errors++; $display("FAIL carry_phase got %h want 00020", bus.phase); end
  endtask

  task automatic test_wrap();
    int lat, nb; logic wd, c1; logic [W-1:0] pd; logic [4:0] b0;
    do_reset();
    run_acc(20'hFFFFF, 0, lat, nb, wd, pd, c1, b0);
    checks++; if (bus.phase !== 20'hFFFFF) begin errors++; $display("FAIL wrap_setup got %h want FFFFF", bus.phase); end
    checks++; if (wd !== 1'b0) begin errors++; $display("FAIL wrap_setup_wrap got %b want 0", wd); end
    run_acc(20'h00001, 0, lat, nb, wd, pd, c1, b0);
    checks++; if (wd !== 1'b1) begin errors++; $display("FAIL wrap_on_done got %b want 1", wd); end
    checks++; if (bus.wrap !== 1'b0) begin errors++; $display("FAIL wrap_after_done got %b want 0", bus.wrap); end
    checks++; if (bus.phase !== 20'h00000) begin errors++; $display("FAIL wrap_phase got %h want 00000", bus.phase); end
  endtask

  task automatic test_back_to_back();
    int d[3]; int n = 0;
    do_reset();
    bus.start = 1'b1;
    bus.step  = 20'h00003;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (bus.done) begin
        d[n] = c; n++;
        if (n == 3) break;
      end
    end
    bus.start = 1'b0;
    checks++; if (n !== 3) begin errors++; $display("FAIL b2b_done_count got %0d want 3", n); end
    checks++; if (n == 3 && (d[1] - d[0]) !== 6) begin errors++; $display("FAIL b2b_gap1 got %0d want 6", d[1] - d[0]); end
    checks++; if (n == 3 && (d[2] - d[1]) !== 6) begin errors++; $display("FAIL b2b_gap2 got %0d want 6", d[2] - d[1]); end
    tick();
    checks++; if (bus.phase !== 20'h00009) begin errors++; $display("FAIL b2b_phase got %h want 00009", bus.phase); end
  endtask

  task automatic test_reset_mid_add();
    int lat, nb, nd; logic wd, c1; logic [W-1:0] pd; logic [4:0] b0;
    run_acc(20'h00009, 0, lat, nb, wd, pd, c1, b0);
    bus.start = 1'b1;
    bus.step  = 20'h00007;
    tick();
    bus.start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b want 0", bus.busy); end
    checks++; if (bus.phase !== 20'h0) begin errors++; $display("FAIL rst_mid_phase got %h want 0", bus.phase); end
    nd = 0;
    for (int c = 0; c < 8; c++) begin
      if (bus.done || bus.wrap) nd++;
      tick();
    end
    checks++; if (nd !== 0) begin errors++; $display("FAIL rst_mid_no_done got %0d pulses want 0", nd); end
    run_acc(20'h00005, 0, lat, nb, wd, pd, c1, b0);
    checks++; if (bus.phase !== 20'h00005) begin errors++; $display("FAIL rst_mid_fresh got %h want 00005", bus.phase); end
  endtask

  task automatic test_step_zero();
    int lat, nb; logic wd, c1; logic [W-1:0] pd; logic [4:0] b0;
    run_acc(20'h00000, 0, lat, nb, wd, pd, c1, b0);
    checks++; if (lat !== 5) begin errors++; $display("FAIL zero_done got %0d want 5", lat); end
    checks++; if (wd !== 1'b0) begin errors++; $display("FAIL zero_wrap got %b want 0", wd); end
    checks++; if (bus.phase !== 20'h00005) begin errors++; $display("FAIL zero_phase got %h want 00005", bus.phase); end
  endtask

`ifdef PHASE_ACC_HARD_SYNC_EN
  task automatic test_hard_sync();
    int lat, nb; logic wd, c1; logic [W-1:0] pd; logic [4:0] b0;
    do_reset();
    run_acc(20'h00100, 0, lat, nb, wd, pd, c1, b0);
    run_acc(20'h00010, 2, lat, nb, wd, pd, c1, b0);
    checks++; if (wd !== 1'b1) begin errors++; $display("FAIL sync_wrap got %b want 1", wd); end
    checks++; if (bus.phase !== 20'h0) begin errors++; $display("FAIL sync_phase got %h want 0", bus.phase); end
    run_acc(20'h00010, 0, lat, nb, wd, pd, c1, b0);
    checks++; if (bus.phase !== 20'h00010) begin errors++; $display("FAIL sync_next got %h want 00010", bus.phase); end
  endtask
`endif

  initial begin
    bus.start = 1'b0;
    bus.step  = '0;
    set_sync(1'b0);
    test_reset();
    test_basic();
    test_carry();
    test_wrap();
    test_back_to_back();
    test_reset_mid_add();
    test_step_zero();
`ifdef PHASE_ACC_HARD_SYNC_EN
    test_hard_sync();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
